// File: rtl/dm_access_pkg.sv
// Shared encodings for the data-memory access controller and its lane unit.
package dm_access_pkg;

  localparam int LANE_W = 8;

  localparam logic [1:0] SZ_BYTE = 2'b00;
  localparam logic [1:0] SZ_HALF = 2'b01;
  localparam logic [1:0] SZ_WORD = 2'b10;
  localparam logic [1:0] SZ_ILL  = 2'b11;

  typedef enum logic [1:0] {
    IDLE,
    ACCESS,
    WRITE,
    RESP
  } state_e;

endpackage

// File: rtl/dm_access_ctrl_lane_unit.sv
// Little-endian lane logic: load extract/extend and sub-word store merge.
module dm_lane_unit
  import dm_access_pkg::*;
(
  input  logic [31:0] dout,
  input  logic [1:0]  lane,
  input  logic [1:0]  size,
  input  logic        sext,
  input  logic [31:0] old_word,
  input  logic [31:0] wdata,
  output logic [31:0] load_data,
  output logic [31:0] merge_data
);

  logic [LANE_W-1:0]   byte_sel;
  logic [2*LANE_W-1:0] half_sel;

  // Halfwords use lane[1] only; odd-lane halves are rejected upstream.
  always_comb begin
    byte_sel   = dout[{lane, 3'b000} +: LANE_W];
    half_sel   = dout[{lane[1], 4'b0000} +: 2*LANE_W];
    load_data  = dout;
    merge_data = wdata;
    case (size)
      SZ_BYTE: begin
        load_data  = {{(32-LANE_W){sext & byte_sel[LANE_W-1]}}, byte_sel};
        merge_data = old_word;
        merge_data[{lane, 3'b000} +: LANE_W] = wdata[LANE_W-1:0];
      end
      SZ_HALF: begin
        load_data  = {{(32-2*LANE_W){sext & half_sel[2*LANE_W-1]}}, half_sel};
        merge_data = old_word;
        merge_data[{lane[1], 4'b0000} +: 2*LANE_W] = wdata[2*LANE_W-1:0];
      end
      default: ;
    endcase
  end

endmodule

// File: rtl/dm_access_ctrl.sv
// Two-port round-robin sequencer for the word-wide data memory, with
// sub-word loads and read-modify-write sub-word stores.
module dm_access_ctrl
  import dm_access_pkg::*;
#(
  parameter int ADDR_W = 10,
  parameter int DATA_W = 32
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              m0_req,
  input  logic              m0_we,
  input  logic [1:0]        m0_size,
  input  logic              m0_sext,
  input  logic [ADDR_W-1:0] m0_addr,
  input  logic [DATA_W-1:0] m0_wdata,
  output logic              m0_ack,
  input  logic              m1_req,
  input  logic              m1_we,
  input  logic [1:0]        m1_size,
  input  logic              m1_sext,
  input  logic [ADDR_W-1:0] m1_addr,
  input  logic [DATA_W-1:0] m1_wdata,
  output logic              m1_ack,
  output logic [DATA_W-1:0] rdata,
  output logic              err,
  output logic [ADDR_W-1:0] mem_addr,
  output logic [DATA_W-1:0] mem_din,
  output logic              mem_we,
  input  logic [DATA_W-1:0] mem_dout
);

  state_e state_q, state_d;

  logic              last_gnt_q, gnt_q, pick;
  logic              we_q, sext_q, err_q;
  logic [1:0]        size_q;
  logic [ADDR_W-1:0] addr_q, base;
  logic [DATA_W-1:0] wdata_q, merge_q, rdata_q;
  logic [DATA_W-1:0] load_data, merge_data;
  logic              illegal, mem_we_raw;

  assign base    = {addr_q[ADDR_W-1:2], 2'b00};
  assign illegal = (size_q == SZ_ILL) ||
                   (size_q == SZ_HALF && addr_q[0]) ||
                   (size_q == SZ_WORD && addr_q[1:0] != 2'b00);
  // last_gnt_q names the requester served most recently; on a tie the other one wins.
  assign pick    = m1_req & (~m0_req | ~last_gnt_q);
  assign rdata   = rdata_q;
  assign err     = err_q;
  assign mem_we  = mem_we_raw & ~rst;

  dm_lane_unit u_lane (
    .dout       (mem_dout),
    .lane       (addr_q[1:0]),
    .size       (size_q),
    .sext       (sext_q),
    .old_word   (merge_q),
    .wdata      (wdata_q),
    .load_data  (load_data),
    .merge_data (merge_data)
  );

  always_comb begin
    state_d    = state_q;
    mem_addr   = '0;
    mem_din    = '0;
    mem_we_raw = 1'b0;
    m0_ack     = 1'b0;
    m1_ack     = 1'b0;
    case (state_q)
      IDLE: if (m0_req || m1_req) state_d = ACCESS;
      ACCESS: begin
        mem_addr = base;
        if (illegal || !we_q) begin
          state_d = RESP;
        end else if (size_q == SZ_WORD) begin
          mem_din    = wdata_q;
          mem_we_raw = 1'b1;
          state_d    = RESP;
        end else begin
          state_d = WRITE;
        end
      end
      WRITE: begin
        mem_addr   = base;
        mem_din    = merge_data;
        mem_we_raw = 1'b1;
        state_d    = RESP;
      end
      RESP: begin
        m0_ack  = ~gnt_q;
        m1_ack  = gnt_q;
        state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q    <= IDLE;
      last_gnt_q <= 1'b1;
      gnt_q      <= 1'b0;
      we_q       <= 1'b0;
      size_q     <= '0;
      sext_q     <= 1'b0;
      addr_q     <= '0;
      wdata_q    <= '0;
      merge_q    <= '0;
      rdata_q    <= '0;
      err_q      <= 1'b0;
    end else begin
      state_q <= state_d;
      case (state_q)
        IDLE: begin
          rdata_q <= '0;
          err_q   <= 1'b0;
          if (m0_req || m1_req) begin
            gnt_q      <= pick;
            last_gnt_q <= pick;
            we_q       <= pick ? m1_we    : m0_we;
            size_q     <= pick ? m1_size  : m0_size;
            sext_q     <= pick ? m1_sext  : m0_sext;
            addr_q     <= pick ? m1_addr  : m0_addr;
            wdata_q    <= pick ? m1_wdata : m0_wdata;
          end
        end
        ACCESS: begin
          err_q   <= illegal;
          rdata_q <= (illegal || we_q) ? '0 : load_data;
          merge_q <= mem_dout;
        end
        default: ;
      endcase
    end
  end

endmodule
